fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DW, default 128, data width of FIFO read data and stream data.
REQ-002 Parameter CW, default 16, width of delivered-word counter.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rstn  input  1  reset, asynchronous, active-high (asserted = 1), despite the port name.
REQ-005 i_en  input  1  enable; 1 = block may issue FIFO reads.
REQ-006 o_rden  output  1  read strobe to FIFO i_rden; one pop per cycle high.
REQ-007 i_rddata  input  DW  FIFO o_rddata; valid exactly 1 cycle after o_rden sampled high.
REQ-008 i_empty  input  1  FIFO o_empty.
REQ-009 i_alm_empty  input  1  FIFO o_alm_empty; status only, mirrored to o_low.
REQ-010 m_valid  output  1  stream data valid.
REQ-011 m_data  output  DW  stream data.
REQ-012 m_ready  input  1  downstream accepts when m_valid && m_ready at posedge.
REQ-013 o_busy  output  1  1 when state != IDLE.
REQ-014 o_low  output  1  registered copy of i_alm_empty (1 cycle delay).
REQ-015 o_wcnt  output  CW  count of completed stream handshakes, modulo 2^CW.

Function
REQ-016 Internal 2-entry in-order buffer; occ = entries held (0..2), infl = reads issued whose data has not yet returned (0..1).
REQ-017 o_rden = state==RUN && !i_empty && (occ + infl - pop) < 2, with pop = m_valid && m_ready; combinational from registered state and inputs.
REQ-018 o_rden never asserted while i_empty=1, regardless of FIFO-side protection.
REQ-019 Cycle after o_rden=1: i_rddata captured into buffer tail; infl cleared unless a new read issued that cycle.
REQ-020 m_valid = occ>0; m_data = buffer head; capture-to-m_valid latency 1 cycle (read issue to m_valid = 2 cycles from empty).
REQ-021 While m_valid && !m_ready, m_data and m_valid held stable.
REQ-022 Simultaneous capture and pop: occ unchanged, order preserved.
REQ-023 Sustained throughput 1 word/cycle when FIFO non-empty and m_ready held 1.
REQ-024 Buffer never overflows: occ+infl <= 2 at all times; violation is a design error.
REQ-025 FSM states IDLE, RUN, DRAIN.
REQ-026 IDLE -> RUN when i_en=1.
REQ-027 RUN -> DRAIN when i_en=0 and (occ>0 or infl>0); RUN -> IDLE when i_en=0 and occ=0 and infl=0.
REQ-028 DRAIN: no new reads; outstanding data delivered; -> IDLE when occ=0, infl=0 and no capture pending; -> RUN if i_en returns to 1.
REQ-029 o_wcnt increments by 1 per handshake, wraps 2^CW-1 -> 0.
REQ-030 i_empty rising while infl=1 does not cancel the pending capture.

Reset
REQ-031 rstn=1 immediately forces: state IDLE, occ=0, infl=0, m_valid=0, m_data=0, o_rden=0, o_busy=0, o_low=0, o_wcnt=0.
REQ-032 Reset mid-transfer discards buffered and in-flight data; first cycle after release behaves as IDLE.
REQ-033 All outputs, including combinational o_rden, are 0 throughout reset.

Verification
REQ-034 FIFO preloaded 0x1,0x2,0x3, i_en=1, m_ready=1 -> o_rden high 3 consecutive cycles, m_data 0x1,0x2,0x3 on consecutive cycles, o_wcnt=3, then IDLE after i_en=0.
REQ-035 FIFO holds 5 words, m_ready=0 -> exactly 2 reads issued, m_valid=1 with m_data=word0 stable; m_ready=1 -> words 0..4 in order, no loss or duplicate.
REQ-036 i_empty=1, i_en=1 for 10 cycles -> o_rden=0 throughout, m_valid=0, o_busy=1.
REQ-037 i_en dropped with occ=2, m_ready=1 -> DRAIN, 2 words delivered, then IDLE, o_rden=0 from cycle i_en=0.
REQ-038 rstn pulsed while occ=1, infl=1 -> all outputs 0 within reset, m_valid=0 after release, o_wcnt=0.
REQ-039 CW=4, 17 handshakes -> o_wcnt=1 (wrap from 15 to 0).

Source files
------------

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus valid/ready output stream
interface fifo_rd_stream_if #(parameter int DW = 128);
    logic          o_rden;
    logic [DW-1:0] i_rddata;
    logic          i_empty;
    logic          i_alm_empty;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    modport master (
        output o_rden, m_valid, m_data,
        input  i_rddata, i_empty, i_alm_empty, m_ready
    );
    modport slave (
        input  o_rden, m_valid, m_data,
        output i_rddata, i_empty, i_alm_empty, m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops a 1-cycle-latency FIFO into a 2-entry buffer feeding a valid/ready stream
module fifo_rd_stream #(
    parameter int DW = 128,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_en,
    fifo_rd_stream_if.master bus,
    output logic            o_busy,
    output logic            o_low,
    output logic [CW-1:0]   o_wcnt
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    logic [1:0]    state, state_n;
    logic [1:0]    occ, tail, need;
    logic          infl, pop;
    logic [DW-1:0] buf0, buf1;
    // tail is the slot a returning word lands in once this cycle's pop has shifted the buffer
    always_comb begin
        pop         = bus.m_valid && bus.m_ready;
        tail        = occ - 2'(pop);
        need        = tail + 2'(infl);
        bus.m_valid = occ != 2'd0;
        bus.m_data  = buf0;
        bus.o_rden  = state == RUN && i_en && !bus.i_empty && need < 2'd2;
        o_busy      = state != IDLE;
        state_n     = (state == IDLE) ? (i_en ? RUN : IDLE) :
                      i_en ? RUN : (occ != 2'd0 || infl) ? DRAIN : IDLE;
    end
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state  <= IDLE;
            occ    <= 2'd0;
            infl   <= 1'b0;
            buf0   <= '0;
            buf1   <= '0;
            o_low  <= 1'b0;
            o_wcnt <= '0;
        end else begin
            state <= state_n;
            infl  <= bus.o_rden;
            occ   <= need;
            o_low <= bus.i_alm_empty;
            if (infl && tail == 2'd0) buf0 <= bus.i_rddata;
            else if (pop) buf0 <= buf1;
            if (infl && tail == 2'd1) buf1 <= bus.i_rddata;
            if (pop) o_wcnt <= o_wcnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: FIFO model plus scoreboard of pushed words checked at each stream handshake
module tb_fifo_rd_stream;
    localparam int DW = 32;
    localparam int CW = 4;
    logic          clk = 1'b0;
    logic          rstn, i_en, o_busy, o_low;
    logic [CW-1:0] o_wcnt;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] wcnt_m = '0;
    int n_chk = 0, n_pass = 0, nrd = 0, nrd0 = 0;
    int rd_run = 0, rd_max = 0, hs_run = 0, hs_max = 0;
    fifo_rd_stream_if #(.DW(DW)) bus();
    fifo_rd_stream #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rstn(rstn), .i_en(i_en), .bus(bus),
        .o_busy(o_busy), .o_low(o_low), .o_wcnt(o_wcnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask
    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        bus.i_empty = 1'b0;
    endtask
    // one clock: sample before the edge, then model the FIFO and score any handshake
    task automatic cyc();
        logic r, hs;
        logic [DW-1:0] d, e;
        #2;
        r  = bus.o_rden;
        hs = bus.m_valid && bus.m_ready;
        d  = bus.m_data;
        @(posedge clk);
        #1;
        if (r) begin
            nrd++;
            rd_run++;
            if (rd_run > rd_max) rd_max = rd_run;
            chk("rden_nonempty", DW'(fq.size() != 0), 1);
            if (fq.size() != 0) bus.i_rddata = fq.pop_front();
        end else rd_run = 0;
        bus.i_empty = fq.size() == 0;
        if (hs) begin
            hs_run++;
            if (hs_run > hs_max) hs_max = hs_run;
            wcnt_m++;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = ~d;
            chk("xfer_data", d, e);
        end else hs_run = 0;
    endtask
    task automatic drain(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            cyc();
            n++;
        end
        chk("drain_timeout", DW'(exp_q.size()), 0);
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_rden"}, bus.o_rden, 0);
        chk({tag, "_valid"}, bus.m_valid, 0);
        chk({tag, "_data"}, bus.m_data, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_low"}, o_low, 0);
        chk({tag, "_wcnt"}, o_wcnt, 0);
    endtask
    initial begin
        rstn = 1'b1;
        i_en = 1'b1;
        bus.i_empty = 1'b1;
        bus.i_alm_empty = 1'b1;
        bus.m_ready = 1'b1;
        bus.i_rddata = '0;
        #12;
        chk_zero("rst");
        @(negedge clk);
        rstn = 1'b0;
        i_en = 1'b0;
        cyc();
        chk("low_set", o_low, 1);
        bus.i_alm_empty = 1'b0;
        cyc();
        chk("low_clr", o_low, 0);
        chk("idle_busy", o_busy, 0);
        // three preloaded words streamed back to back
        push(32'h1); push(32'h2); push(32'h3);
        i_en = 1'b1;
        rd_max = 0; hs_max = 0; nrd0 = nrd;
        repeat (8) cyc();
        chk("burst_rd_streak", rd_max, 3);
        chk("burst_rd_count", nrd - nrd0, 3);
        chk("burst_hs_streak", hs_max, 3);
        chk("burst_wcnt", o_wcnt, 3);
        i_en = 1'b0;
        repeat (2) cyc();
        chk("burst_idle", o_busy, 0);
        // enabled on an empty FIFO
        i_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("empty_rden", bus.o_rden, 0);
            chk("empty_valid", bus.m_valid, 0);
        end
        chk("empty_busy", o_busy, 1);
        // backpressure: only two reads fit, head held stable
        bus.m_ready = 1'b0;
        for (int k = 0; k < 5; k++) push(32'h10 + k);
        nrd0 = nrd;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i >= 2) begin
                chk("bp_valid", bus.m_valid, 1);
                chk("bp_hold", bus.m_data, 32'h10);
            end
        end
        chk("bp_rd_count", nrd - nrd0, 2);
        bus.m_ready = 1'b1;
        drain(40);
        chk("bp_wcnt", o_wcnt, wcnt_m);
        // drop enable with a full buffer
        bus.m_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(32'h20 + k);
        repeat (6) cyc();
        chk("dr_full", bus.m_valid, 1);
        i_en = 1'b0;
        bus.m_ready = 1'b1;
        nrd0 = nrd;
        cyc();
        chk("dr_busy", o_busy, 1);
        repeat (2) cyc();
        chk("dr_idle", o_busy, 0);
        repeat (3) cyc();
        chk("dr_no_rd", nrd - nrd0, 0);
        chk("dr_left", DW'(exp_q.size()), 2);
        i_en = 1'b1;
        drain(20);
        // reset with one word held and one in flight
        bus.m_ready = 1'b0;
        bus.i_alm_empty = 1'b1;
        push(32'h30); push(32'h31); push(32'h32);
        cyc(); cyc();
        chk("mid_valid", bus.m_valid, 1);
        chk("mid_low", o_low, 1);
        #1;
        rstn = 1'b1;
        #1;
        chk_zero("mid_rst");
        fq.delete();
        exp_q.delete();
        bus.i_empty = 1'b1;
        bus.i_alm_empty = 1'b0;
        wcnt_m = '0;
        i_en = 1'b0;
        bus.m_ready = 1'b1;
        cyc();
        rstn = 1'b0;
        cyc();
        chk("post_valid", bus.m_valid, 0);
        chk("post_wcnt", o_wcnt, 0);
        chk("post_busy", o_busy, 0);
        // 17 handshakes wrap a 4-bit counter to 1
        for (int k = 0; k < 17; k++) push(32'h40 + k);
        i_en = 1'b1;
        drain(60);
        chk("wrap_wcnt", o_wcnt, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
